// File: rtl/sao_pkg.sv
// rtl/sao_pkg.sv - shared constants, state encoding and address mapping for the SAO frame path
package sao_pkg;

    localparam int FRAME_DIM   = 128;
    localparam int ADDR_W      = 14;

    localparam logic [1:0] LCU_16 = 2'd0;
    localparam logic [1:0] LCU_32 = 2'd1;
    localparam logic [1:0] LCU_64 = 2'd2;

    localparam int BEATS_16    = 256;
    localparam int BEATS_32    = 1024;
    localparam int BEATS_64    = 4096;
    localparam int BEATS_FRAME = FRAME_DIM * FRAME_DIM;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Position counter: row bits sit above column bits, LCU index fills the bits in between.
    function automatic logic [ADDR_W-1:0] sao_addr(input logic              lcu_mode,
                                                   input logic [1:0]        lcu_size,
                                                   input logic [2:0]        lcu_x,
                                                   input logic [2:0]        lcu_y,
                                                   input logic [ADDR_W-1:0] pos);
        logic [ADDR_W-1:0] a;
        if (!lcu_mode) begin
            a = pos;
        end else begin
            case (lcu_size)
                LCU_16:  a = {lcu_y,      pos[7:4],  lcu_x,      pos[3:0]};
                LCU_32:  a = {lcu_y[1:0], pos[9:5],  lcu_x[1:0], pos[4:0]};
                default: a = {lcu_y[0],   pos[11:6], lcu_x[0],   pos[5:0]};
            endcase
        end
        return a;
    endfunction

    function automatic logic [ADDR_W-1:0] sao_last_pos(input logic       lcu_mode,
                                                       input logic [1:0] lcu_size);
        logic [ADDR_W-1:0] p;
        if (!lcu_mode) begin
            p = ADDR_W'(BEATS_FRAME - 1);
        end else begin
            case (lcu_size)
                LCU_16:  p = ADDR_W'(BEATS_16 - 1);
                LCU_32:  p = ADDR_W'(BEATS_32 - 1);
                default: p = ADDR_W'(BEATS_64 - 1);
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/sao_reader_fifo.sv
// rtl/sao_reader_fifo.sv - small synchronous skid FIFO with occupancy output
module sao_reader_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 9,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [OW-1:0] occ_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0] occ_q, occ_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (push_i) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        if (pop_i)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign occ_o   = occ_q;

endmodule

// File: rtl/sao_frame_reader.sv
// rtl/sao_frame_reader.sv - frame/LCU read-back streamer; SAO_READER_CHECKSUM_EN adds checksum_o
module sao_frame_reader
    import sao_pkg::*;
#(
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              lcu_mode_i,
    input  logic [2:0]        lcu_x_i,
    input  logic [2:0]        lcu_y_i,
    input  logic [1:0]        lcu_size_i,
    output logic              sram_cen_o,
    output logic              sram_wen_o,
    output logic [ADDR_W-1:0] sram_a_o,
    input  logic [7:0]        sram_q_i,
    output logic [7:0]        dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              dout_last_o,
`ifdef SAO_READER_CHECKSUM_EN
    output logic [15:0]       checksum_o,
`endif
    output logic              busy_o,
    output logic              done_o
);

    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(FIFO_DEPTH + LAT + 1);

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [1:0]        size_q, size_d;
    logic [2:0]        x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [LAT-1:0]    vpipe_q, vpipe_d, lpipe_q, lpipe_d;

    logic [OW-1:0]     occ;
    logic [8:0]        fifo_rdata;
    logic [CW-1:0]     inflight;
    logic              issue, is_final, land, fifo_empty, push, pop, fire;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + CW'(vpipe_q[i]);
    end

    // Reserve a FIFO slot for every read before it is issued so nothing can be dropped.
    assign issue    = (state_q == ST_READ) && ((CW'(occ) + inflight) < CW'(FIFO_DEPTH));
    assign is_final = (cnt_q == sao_last_pos(mode_q, size_q));
    assign land     = vpipe_q[LAT-1];

    always_comb begin
        vpipe_d[0] = issue;
        lpipe_d[0] = issue && is_final;
        for (int i = 1; i < LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
            lpipe_d[i] = lpipe_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        size_d  = size_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_READ;
                    mode_d  = lcu_mode_i;
                    size_d  = lcu_size_i;
                    x_d     = lcu_x_i;
                    y_d     = lcu_y_i;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (is_final) state_d = ST_DRAIN;
                    else          cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (fire && dout_last_o) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            size_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            vpipe_q <= '0;
            lpipe_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            size_q  <= size_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            vpipe_q <= vpipe_d;
            lpipe_q <= lpipe_d;
        end
    end

    // Landing data bypasses the FIFO when it is empty so first valid is LAT cycles after issue.
    assign fifo_empty   = (occ == '0);
    assign push         = land && !(fifo_empty && dout_ready_i);
    assign pop          = !fifo_empty && dout_ready_i;
    assign dout_valid_o = !fifo_empty || land;
    assign dout_o       = !fifo_empty ? fifo_rdata[7:0] : (land ? sram_q_i : 8'd0);
    assign dout_last_o  = !fifo_empty ? fifo_rdata[8] : (land && lpipe_q[LAT-1]);
    assign fire         = dout_valid_o && dout_ready_i;

    sao_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (9)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i ({lpipe_q[LAT-1], sram_q_i}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .occ_o   (occ)
    );

    assign sram_cen_o = !issue;
    assign sram_wen_o = 1'b1;
    assign sram_a_o   = sao_addr(mode_q, size_q, x_q, y_q, cnt_q);
    assign busy_o     = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);

`ifdef SAO_READER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else if (state_q == ST_IDLE && start_i) begin
            sum_q <= '0;
        end else if (fire) begin
            sum_q <= sum_q + {8'd0, dout_o};
        end
    end

    assign checksum_o = sum_q;
`endif

endmodule

// File: tb/tb_sao_frame_reader.sv
// tb/tb_sao_frame_reader.sv - randomized scoreboard bench for sao_frame_reader
module tb_sao_frame_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        lcu_mode = 1'b0;
    logic [2:0]  lcu_x = '0, lcu_y = '0;
    logic [1:0]  lcu_size = '0;
    logic        sram_cen, sram_wen;
    logic [13:0] sram_a;
    logic [7:0]  sram_q = '0;
    logic [7:0]  dout;
    logic        dout_valid, dout_last, busy, done;
    logic        dout_ready = 1'b1;
`ifdef SAO_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk = ~clk;

    sao_frame_reader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .lcu_mode_i   (lcu_mode),
        .lcu_x_i      (lcu_x),
        .lcu_y_i      (lcu_y),
        .lcu_size_i   (lcu_size),
        .sram_cen_o   (sram_cen),
        .sram_wen_o   (sram_wen),
        .sram_a_o     (sram_a),
        .sram_q_i     (sram_q),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .dout_ready_i (dout_ready),
        .dout_last_o  (dout_last),
`ifdef SAO_READER_CHECKSUM_EN
        .checksum_o   (checksum),
`endif
        .busy_o       (busy),
        .done_o       (done)
    );

    logic [7:0] mem [16384];
    always @(posedge clk) if (!sram_cen) sram_q <= mem[sram_a];

    int          checks = 0, failures = 0;
    int          cyc = 0, t0 = 0, accepted = 0, done_count = 0, done_cyc = 0;
    logic [8:0]  exp_q[$];
    logic [13:0] addr_q[$];
    bit          expect_done = 0, stalled = 0, rand_ready = 0;
    logic [8:0]  held, exp_beat;
    logic [15:0] exp_sum;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int lcu_dim(input logic [1:0] size);
        return (size == 2'd0) ? 16 : (size == 2'd1) ? 32 : 64;
    endfunction

    // Reference: k-th pixel of a raster walk over an S x S tile of the 128-wide frame.
    function automatic logic [13:0] ref_addr(input logic mode, input logic [1:0] size,
                                             input logic [2:0] x, input logic [2:0] y, input int k);
        int s, xe, ye;
        if (!mode) return 14'(k);
        s  = lcu_dim(size);
        xe = int'(x) % (128 / s);
        ye = int'(y) % (128 / s);
        return 14'((ye * s + k / s) * 128 + xe * s + k % s);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled     = 0;
            expect_done = 0;
        end else begin
            if (expect_done) begin
                check("done_pulse", 32'(done), 32'd1);
                check("busy_fall", 32'(busy), 32'd0);
                done_count++;
                done_cyc    = cyc - t0;
                expect_done = 0;
            end else if (done) begin
                check("spurious_done", 32'(done), 32'd0);
            end
            if (!sram_cen) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_read addr=%0h required=no read", sram_a);
                end else begin
                    check("read_addr", 32'(sram_a), 32'(addr_q.pop_front()));
                end
            end
            if (stalled) begin
                check("stall_valid", 32'(dout_valid), 32'd1);
                check("stall_data", 32'({dout_last, dout}), 32'(held));
            end
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat dout=%0h required=no beat", dout);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("dout", 32'(dout), 32'(exp_beat[7:0]));
                    check("dout_last", 32'(dout_last), 32'(exp_beat[8]));
                end
                accepted++;
                if (dout_last) expect_done = 1;
            end
            stalled = dout_valid && !dout_ready;
            held    = {dout_last, dout};
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cen"},   32'(sram_cen),   32'd1);
        check({tag, "_addr"},  32'(sram_a),     32'd0);
        check({tag, "_dout"},  32'(dout),       32'd0);
        check({tag, "_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_last"},  32'(dout_last),  32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
    endtask

    task automatic run(input logic mode, input logic [1:0] size, input logic [2:0] x,
                       input logic [2:0] y, input bit rr, input int repulse_at,
                       input bit pulse_at_done, input int abort_at);
        int n, acc0, dc0;
        bit finished;
        logic [13:0] a;
        n        = mode ? lcu_dim(size) * lcu_dim(size) : 16384;
        exp_sum  = '0;
        for (int k = 0; k < n; k++) begin
            a = ref_addr(mode, size, x, y, k);
            addr_q.push_back(a);
            exp_q.push_back({k == n - 1, mem[a]});
            exp_sum = exp_sum + 16'(mem[a]);
        end
        rand_ready = rr;
        acc0       = accepted;
        dc0        = done_count;
        finished   = 0;
        @(posedge clk);
        #1;
        lcu_mode = mode; lcu_size = size; lcu_x = x; lcu_y = y;
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lcu_mode = ~mode;
        lcu_size = 2'($urandom_range(0, 3));
        lcu_x    = ~x;
        lcu_y    = ~y;
        @(negedge clk);
        check("busy_cycle1", 32'(busy), 32'd1);
        check("cen_cycle1", 32'(sram_cen), 32'd0);
        @(negedge clk);
        check("valid_cycle2", 32'(dout_valid), 32'd1);
        for (int c = 3; c < n * 4 + 50 && !finished; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == repulse_at) begin
                start = 1'b1;
                lcu_mode = 1'b1; lcu_size = 2'd0; lcu_x = 3'd7; lcu_y = 3'd7;
            end
            if (abort_at >= 0 && (accepted - acc0) >= abort_at) begin
                rst_n = 1'b0;
                exp_q.delete();
                addr_q.delete();
                @(negedge clk);
                check_reset_vals("abort");
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                repeat (6) @(negedge clk);
                check("abort_no_done", 32'(done_count - dc0), 32'd0);
                return;
            end
            if (done) begin
                start = pulse_at_done;
                @(posedge clk);
                #1;
                start = 1'b0;
                @(negedge clk);
                check("restart_ignored_busy", 32'(busy), 32'd0);
                check("restart_ignored_cen", 32'(sram_cen), 32'd1);
                finished = 1;
            end
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL timeout beats=%0d required=%0d", accepted - acc0, n);
        end
        check("beat_count", 32'(accepted - acc0), 32'(n));
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        check("addr_drained", 32'(addr_q.size()), 32'd0);
        check("done_once", 32'(done_count - dc0), 32'd1);
        if (!rr) check("done_cycle", 32'(done_cyc), 32'(n + 2));
`ifdef SAO_READER_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(exp_sum));
`endif
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("in_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        run(1'b0, 2'd0, 3'd0, 3'd0, 1'b0, -1, 1'b0, -1);

        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        run(1'b1, 2'd0, 3'd3, 3'd5, 1'b0, -1, 1'b0, -1);
        begin
            logic [2:0] rx, ry;
            rx = 3'($urandom_range(0, 7));
            ry = 3'($urandom_range(0, 7));
            run(1'b1, 2'd1, rx, ry, 1'b0, -1, 1'b0, -1);
            run(1'b1, 2'd1, rx, ry, 1'b1, -1, 1'b1, -1);
            run(1'b1, 2'd3, ry, rx, 1'b1, 100, 1'b0, -1);
        end
        run(1'b1, 2'd0, 3'd6, 3'd1, 1'b0, 100, 1'b1, -1);
        run(1'b0, 2'd0, 3'd0, 3'd0, 1'b1, -1, 1'b0, 500);
        run(1'b1, 2'd0, 3'd0, 3'd0, 1'b0, -1, 1'b0, -1);

`ifdef SAO_READER_CHECKSUM_EN
        for (int i = 0; i < 16384; i++) mem[i] = 8'hFF;
        run(1'b0, 2'd0, 3'd0, 3'd0, 1'b0, -1, 1'b0, -1);
        check("checksum_all_ff", 32'(checksum), 32'h0000C000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
